bsg_manycore_tunnel_credit_sched: RTL and testbench



---
 rtl/bsg_manycore_tunnel_credit_sched_if.sv | 28 ++
 rtl/bsg_manycore_tunnel_credit_sched.sv | 194 +++++++++++++++++++
 tb/tb_bsg_manycore_tunnel_credit_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_tunnel_credit_sched_if.sv
// Handshake bundle of the tunnel credit scheduler: per-channel fifo heads,
// local consume events, far-side credit returns and the multiplexed output.
interface bsg_manycore_tunnel_credit_sched_if #(
   parameter int num_in_p = 4,
   parameter int width_p  = 16
);
   localparam int tag_width_lp = $clog2(num_in_p + 1);

   logic [num_in_p*width_p-1:0]     data_i;
   logic [num_in_p-1:0]             v_i;
   logic [num_in_p-1:0]             yumi_o;
   logic [num_in_p-1:0]             consume_v_i;
   logic                            credit_v_i;
   logic [width_p-1:0]              credit_data_i;
   logic                            multi_v_o;
   logic [tag_width_lp+width_p-1:0] multi_data_o;
   logic                            multi_yumi_i;

   modport master (
      output data_i, v_i, consume_v_i, credit_v_i, credit_data_i, multi_yumi_i,
      input  yumi_o, multi_v_o, multi_data_o
   );

   modport slave (
      input  data_i, v_i, consume_v_i, credit_v_i, credit_data_i, multi_yumi_i,
      output yumi_o, multi_v_o, multi_data_o
   );
endinterface

// File: rtl/bsg_manycore_tunnel_credit_sched.sv
// Credit-based round-robin scheduler muxing tunnelled channels onto one tagged stream.
// Optional: define BSG_TUNNEL_SCHED_STATS_EN to add the stall_cnt_o counter.
module bsg_manycore_tunnel_credit_sched_chk (
   input logic clk_i,
   input logic reset_i,
   input logic cred_ovf_i,
   input logic hold_drop_i
);
   a_cred_ovf: assert property (@(posedge clk_i) disable iff (reset_i) !cred_ovf_i)
      else $fatal(1, "credit counter exceeds remote_credits_p");
   a_hold_drop: assert property (@(posedge clk_i) disable iff (reset_i) !hold_drop_i)
      else $fatal(1, "held channel dropped v_i before yumi");
endmodule

module bsg_manycore_tunnel_credit_sched #(
   parameter int num_in_p         = 4,
   parameter int width_p          = 16,
   parameter int remote_credits_p = 8,
   parameter int credit_batch_p   = 4
) (
   input  logic clk_i,
   input  logic reset_i,
`ifdef BSG_TUNNEL_SCHED_STATS_EN
   output logic [31:0] stall_cnt_o,
`endif
   bsg_manycore_tunnel_credit_sched_if.slave link
);
   localparam int credit_width_lp = $clog2(remote_credits_p + 1);
   localparam int tag_width_lp    = $clog2(num_in_p + 1);
   localparam int ptr_width_lp    = (num_in_p > 1) ? $clog2(num_in_p) : 1;
   localparam logic [tag_width_lp-1:0] credit_tag_lp = tag_width_lp'(num_in_p);

   typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_e;

   state_e                      state_r, state_n;
   logic [credit_width_lp-1:0]  cred_r [num_in_p];
   logic [credit_width_lp-1:0]  cons_r [num_in_p];
   logic [credit_width_lp:0]    cred_n_s [num_in_p];
   logic [credit_width_lp-1:0]  cons_n_s [num_in_p];
   logic [width_p-1:0]          data_arr_s [num_in_p];
   logic [ptr_width_lp-1:0]     ptr_r, rr_idx_s, pos_s, out_idx_s;
   logic [tag_width_lp-1:0]     sel_r, cand_tag_s, out_tag_s;
   logic [width_p-1:0]          hold_pay_r, credit_pay_s, out_pay_s;
   logic [num_in_p-1:0]         cred_nz_s, eligible_s, sent_s;
   logic                        urgent_s, rr_found_s, cand_v_s, out_v_s, out_credit_s;
   logic                        fire_s, latch_s, cred_ovf_s, hold_drop_s;

   // Channel views, eligibility and the credit-return payload snapshot source.
   always_comb begin
      urgent_s     = 1'b0;
      credit_pay_s = '0;
      cred_nz_s    = '0;
      data_arr_s   = '{default: '0};
      for (int c = 0; c < num_in_p; c++) begin
         data_arr_s[c] = link.data_i[c*width_p +: width_p];
         credit_pay_s[c*credit_width_lp +: credit_width_lp] = cons_r[c];
         cred_nz_s[c]  = (cred_r[c] != '0);
         urgent_s      = urgent_s | (cons_r[c] >= credit_width_lp'(credit_batch_p));
      end
      eligible_s = link.v_i & cred_nz_s;
   end

   // Round-robin search; the nearest eligible channel after ptr is written last and wins.
   always_comb begin
      rr_found_s = 1'b0;
      rr_idx_s   = '0;
      pos_s      = '0;
      for (int i = num_in_p; i >= 1; i--) begin
         pos_s = ptr_width_lp'((int'(ptr_r) + i) % num_in_p);
         if (eligible_s[pos_s]) begin
            rr_found_s = 1'b1;
            rr_idx_s   = pos_s;
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // Output selection: live candidate in IDLE, latched choice in HOLD.
   always_comb begin
      cand_v_s     = urgent_s | rr_found_s;
      cand_tag_s   = urgent_s ? credit_tag_lp : tag_width_lp'(rr_idx_s);
      out_tag_s    = (state_r == HOLD) ? sel_r : cand_tag_s;
      out_v_s      = ~reset_i & ((state_r == HOLD) | cand_v_s);
      out_credit_s = (out_tag_s == credit_tag_lp);
      out_idx_s    = ptr_width_lp'(out_tag_s);
      if (out_credit_s) begin
         out_pay_s = (state_r == HOLD) ? hold_pay_r : credit_pay_s;
      end else begin
         out_pay_s = data_arr_s[out_idx_s];
      end
      fire_s = out_v_s & link.multi_yumi_i;
      sent_s = '0;
      for (int c = 0; c < num_in_p; c++) begin
         sent_s[c] = fire_s & ~out_credit_s & (out_idx_s == ptr_width_lp'(c));
      end
      hold_drop_s = (state_r == HOLD) & ~out_credit_s & ~link.v_i[out_idx_s];
   end

   assign link.multi_v_o    = out_v_s;
   assign link.multi_data_o = {out_tag_s, out_pay_s};
   assign link.yumi_o       = sent_s;

   // Counter next values; consumed counts restart from this cycle's event on a credit send.
   always_comb begin
      cred_ovf_s = 1'b0;
      for (int c = 0; c < num_in_p; c++) begin
         cred_n_s[c] = {1'b0, cred_r[c]}
                     + (link.credit_v_i ? {1'b0, link.credit_data_i[c*credit_width_lp +: credit_width_lp]}
                                        : {(credit_width_lp+1){1'b0}})
                     - {{credit_width_lp{1'b0}}, sent_s[c]};
         cred_ovf_s  = cred_ovf_s | (cred_n_s[c] > (credit_width_lp+1)'(remote_credits_p));
         if (fire_s && out_credit_s) begin
            cons_n_s[c] = {{(credit_width_lp-1){1'b0}}, link.consume_v_i[c]};
         end else if (link.consume_v_i[c] && (cons_r[c] < credit_width_lp'(remote_credits_p))) begin
            cons_n_s[c] = cons_r[c] + {{(credit_width_lp-1){1'b0}}, 1'b1};
         end else begin
            cons_n_s[c] = cons_r[c];
         end
      end
   end

   // IDLE/HOLD next state: a presented but unaccepted packet is frozen until taken.
   always_comb begin
      state_n = state_r;
      latch_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (cand_v_s && !link.multi_yumi_i) begin
               state_n = HOLD;
               latch_s = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         HOLD: begin
            if (link.multi_yumi_i) begin
               state_n = IDLE;
            end else begin
               state_n = HOLD;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, pointer, latched selection and counters.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r    <= IDLE;
         ptr_r      <= ptr_width_lp'(num_in_p - 1);
         sel_r      <= '0;
         hold_pay_r <= '0;
         for (int c = 0; c < num_in_p; c++) begin
            cred_r[c] <= credit_width_lp'(remote_credits_p);
            cons_r[c] <= '0;
         end
      end else begin
         state_r <= state_n;
         if (fire_s && !out_credit_s) begin
            ptr_r <= out_idx_s;
         end
         if (latch_s) begin
            sel_r      <= cand_tag_s;
            hold_pay_r <= credit_pay_s;
         end
         for (int c = 0; c < num_in_p; c++) begin
            cred_r[c] <= cred_n_s[c][credit_width_lp-1:0];
            cons_r[c] <= cons_n_s[c];
         end
      end
   end

`ifdef BSG_TUNNEL_SCHED_STATS_EN
   logic stall_s;
   assign stall_s = |(link.v_i & ~cred_nz_s);

   // Saturating count of cycles where pending data is blocked on credit.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cnt_o <= 32'd0;
      end else if (stall_s && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

   bsg_manycore_tunnel_credit_sched_chk chk (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .cred_ovf_i (cred_ovf_s),
      .hold_drop_i(hold_drop_s)
   );
endmodule

// File: tb/tb_bsg_manycore_tunnel_credit_sched.sv
// Scoreboard bench: directed stimulus pushes expected {tag,payload}; a negedge monitor pops on each accepted packet.
module tb_bsg_manycore_tunnel_credit_sched;
   localparam int num_in_p = 4;
   localparam int width_p  = 16;

   logic        clk = 1'b0;
   logic        reset_i;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [18:0] sb_q [$];
   logic [18:0] exp_w;
   logic [3:0]  exp_yumi;

   always #5 clk = ~clk;

   bsg_manycore_tunnel_credit_sched_if #(.num_in_p(num_in_p), .width_p(width_p)) link ();

`ifdef BSG_TUNNEL_SCHED_STATS_EN
   logic [31:0] stall_cnt;
`endif

   bsg_manycore_tunnel_credit_sched #(
      .num_in_p(num_in_p), .width_p(width_p), .remote_credits_p(8), .credit_batch_p(4)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset_i),
`ifdef BSG_TUNNEL_SCHED_STATS_EN
      .stall_cnt_o(stall_cnt),
`endif
      .link   (link)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
      #1;
      check(name, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic idle_check(input string name);
      @(negedge clk);
      check(name, 32'(link.multi_v_o), 32'd0);
      sync();
   endtask

   // Monitor: every accepted packet must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset_i && link.multi_v_o && link.multi_yumi_i) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_extra: got %h, required no packet", link.multi_data_o);
         end else begin
            exp_w    = sb_q.pop_front();
            exp_yumi = (exp_w[18:16] < 3'd4) ? (4'b0001 << exp_w[18:16]) : 4'b0000;
            check("sb_data", 32'(link.multi_data_o), 32'(exp_w));
            check("sb_yumi", 32'(link.yumi_o), 32'(exp_yumi));
         end
      end else if (!reset_i) begin
         check("yumi_idle", 32'(link.yumi_o), 32'd0);
      end
   end

   initial begin
      reset_i            = 1'b1;
      link.data_i        = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      link.v_i           = 4'hF;
      link.consume_v_i   = 4'h0;
      link.credit_v_i    = 1'b0;
      link.credit_data_i = 16'h0000;
      link.multi_yumi_i  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_v", 32'(link.multi_v_o), 32'd0);
      check("rst_yumi", 32'(link.yumi_o), 32'd0);

      // Full credit drain: 8 rounds of tags 0..3, then blocked.
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) sb_q.push_back({3'(c), 16'hA000 | 16'(c)});
      link.multi_yumi_i = 1'b1;
      reset_i           = 1'b0;
      wait_drain("drain_initial", 40);
      idle_check("blocked_idle");

      // Credit return of 3 to channel 2.
      for (int i = 0; i < 3; i++) sb_q.push_back({3'd2, 16'hA002});
      link.credit_v_i    = 1'b1;
      link.credit_data_i = 16'h0300;
      sync();
      link.credit_v_i    = 1'b0;
      @(negedge clk);
      check("cred_next_cycle", 32'(link.multi_data_o), 32'({3'd2, 16'hA002}));
      wait_drain("drain_ch2", 10);
      idle_check("ch2_idle");

      // Consume batch on channel 1, including a consume in the credit yumi cycle.
      sb_q.push_back({3'd4, 16'h0040});
      sb_q.push_back({3'd4, 16'h0040});
      link.consume_v_i = 4'b0010;
      repeat (8) sync();
      link.consume_v_i = 4'b0000;
      wait_drain("drain_credit_pkts", 10);
      idle_check("credit_idle");

      // Hold channel 0 for 5 cycles while channel 3 becomes urgent.
      link.multi_yumi_i  = 1'b0;
      link.credit_v_i    = 1'b1;
      link.credit_data_i = 16'h0002;
      sync();
      link.credit_v_i    = 1'b0;
      link.consume_v_i   = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_v", 32'(link.multi_v_o), 32'd1);
         check("hold_data", 32'(link.multi_data_o), 32'({3'd0, 16'hA000}));
         sync();
         if (i == 3) link.consume_v_i = 4'b0000;
      end
      sb_q.push_back({3'd0, 16'hA000});
      sb_q.push_back({3'd4, 16'h4000});
      sb_q.push_back({3'd0, 16'hA000});
      link.multi_yumi_i = 1'b1;
      wait_drain("drain_hold", 10);
      idle_check("hold_idle");

      // Channel 3 at 5 credits, then a send with +2 credit in the same cycle.
      link.multi_yumi_i  = 1'b0;
      link.credit_v_i    = 1'b1;
      link.credit_data_i = 16'h5000;
      sync();
      for (int i = 0; i < 7; i++) sb_q.push_back({3'd3, 16'hA003});
      link.credit_data_i = 16'h2000;
      link.multi_yumi_i  = 1'b1;
      sync();
      link.credit_v_i    = 1'b0;
      wait_drain("drain_net_credit", 15);
      idle_check("net_idle");

      // Asynchronous reset while channel 1 is held.
      link.multi_yumi_i  = 1'b0;
      link.credit_v_i    = 1'b1;
      link.credit_data_i = 16'h0020;
      sync();
      link.credit_v_i    = 1'b0;
      sync();
      @(negedge clk);
      check("pre_rst_hold", 32'(link.multi_data_o), 32'({3'd1, 16'hA001}));
      #2;
      reset_i = 1'b1;
      #1;
      check("midhold_rst_v", 32'(link.multi_v_o), 32'd0);
      check("midhold_rst_yumi", 32'(link.yumi_o), 32'd0);
`ifdef BSG_TUNNEL_SCHED_STATS_EN
      check("stall_rst", stall_cnt, 32'd0);
`endif
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) sb_q.push_back({3'(c), 16'hA000 | 16'(c)});
      @(posedge clk);
      #1;
      link.multi_yumi_i = 1'b1;
      reset_i           = 1'b0;
      wait_drain("drain_after_rst", 40);
      idle_check("final_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
